// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter: N requesters share one registered W-bit output stage.
// A grant lasts one transfer, or up to MAX_BURST transfers while the winner holds LOCK.
module rr_reg_arbiter #(
   parameter int N         = 4,
   parameter int W         = 8,
   parameter int MAX_BURST = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   lock,
   input  logic [N*W-1:0] in,
   output logic [N-1:0]   gnt,
   output logic [W-1:0]   out,
   output logic           out_vld,
   output logic           busy
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state_reg, state_next;
   logic [PW-1:0]   ptr_reg, ptr_next;
   logic [PW-1:0]   win_reg, win_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [N-1:0]    gnt_reg, gnt_next;
   logic [W-1:0]    out_reg, out_next;
   logic            vld_reg, vld_next;

   logic [PW-1:0]   win_sel;
   logic [N-1:0]    win_onehot;
   logic [CW-1:0]   cnt_inc;
   logic [PW-1:0]   ptr_after;

   // Scan from the highest rotated offset down so the nearest request to ptr wins.
   always_comb begin
      win_sel = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[(int'(ptr_reg) + k) % N]) begin
            win_sel = PW'((int'(ptr_reg) + k) % N);
         end
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign win_onehot[gi] = (win_sel == PW'(gi));
   end

   assign cnt_inc   = cnt_reg + CW'(1);
   assign ptr_after = (win_reg == PW'(N - 1)) ? '0 : win_reg + PW'(1);

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      win_next   = win_reg;
      cnt_next   = cnt_reg;
      gnt_next   = gnt_reg;
      out_next   = out_reg;
      vld_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (|req) begin
               win_next   = win_sel;
               gnt_next   = win_onehot;
               cnt_next   = '0;
               state_next = GRANT;
            end
         end
         GRANT: begin
            if (req[win_reg]) begin
               out_next = in[int'(win_reg)*W +: W];
               vld_next = 1'b1;
               cnt_next = cnt_inc;
            end
            // A withdraw, an unlocked transfer or an exhausted burst all release.
            if (!req[win_reg] || !(lock[win_reg] && (int'(cnt_inc) < MAX_BURST))) begin
               gnt_next   = '0;
               ptr_next   = ptr_after;
               state_next = IDLE;
            end
         end
         default: begin
            gnt_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
         win_reg   <= '0;
         cnt_reg   <= '0;
         gnt_reg   <= '0;
         out_reg   <= '0;
         vld_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         win_reg   <= win_next;
         cnt_reg   <= cnt_next;
         gnt_reg   <= gnt_next;
         out_reg   <= out_next;
         vld_reg   <= vld_next;
      end
   end

   assign gnt     = gnt_reg;
   assign out     = out_reg;
   assign out_vld = vld_reg;
   assign busy    = (state_reg == GRANT);

endmodule
